// File: rtl/dtcm_port_arbiter.sv
// dtcm_port_arbiter: shares the single-port DTCM SRAM between the core
// load/store port (m0, priority) and the loader/DMA port (m1). A
// starvation counter forces one m1 grant after STARVE_LIMIT denied cycles.
// Read data (1-cycle SRAM latency) is steered back to the granted owner.
module dtcm_port_arbiter #(
    parameter int AW           = 24,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            cpurst,
    // core load/store port
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdat,
    input  logic [DW/8-1:0] m0_be,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdat,
    // loader/DMA port
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdat,
    input  logic [DW/8-1:0] m1_be,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdat,
    // SRAM macro side
    output logic            sram_cs,
    output logic            sram_we,
    output logic [AW-3:0]   sram_addr,
    output logic [DW-1:0]   sram_wdat,
    output logic [DW/8-1:0] sram_be,
    input  logic [DW-1:0]   sram_rdat
);

    logic [3:0] starve_cnt;
    logic       force_m1;
    logic       rd_pend;
    logic       rd_owner;   // 0 = m0, 1 = m1

    // byte-offset bits never reach the word-addressed SRAM
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    // Core wins ties unless m1 has been denied STARVE_LIMIT cycles in a row.
    assign force_m1 = m1_req & (starve_cnt == 4'(STARVE_LIMIT));
    assign m1_gnt   = m1_req & (force_m1 | ~m0_req);
    assign m0_gnt   = m0_req & ~m1_gnt;
    assign sram_cs  = m0_gnt | m1_gnt;

    // Route the winner onto the SRAM; idle cycles drive zeros.
    always_comb begin
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_wdat = '0;
        sram_be   = '0;
        if (m1_gnt) begin
            sram_we   = m1_we;
            sram_addr = m1_addr[AW-1:2];
            sram_wdat = m1_wdat;
            sram_be   = m1_we ? m1_be : '1;
        end else if (m0_gnt) begin
            sram_we   = m0_we;
            sram_addr = m0_addr[AW-1:2];
            sram_wdat = m0_wdat;
            sram_be   = m0_we ? m0_be : '1;
        end
    end

    // Count consecutive m1 denials; any grant or dropped request clears it.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            starve_cnt <= '0;
        end else if (m1_req && !m1_gnt) begin
            if (starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Remember who owns the read in flight so its data returns to them only.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= sram_cs & ~sram_we;
            if (sram_cs && !sram_we)
                rd_owner <= m1_gnt;
        end
    end

    assign m0_rvalid = rd_pend & ~rd_owner;
    assign m1_rvalid = rd_pend &  rd_owner;
    assign m0_rdat   = m0_rvalid ? sram_rdat : '0;
    assign m1_rdat   = m1_rvalid ? sram_rdat : '0;

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Bench for dtcm_port_arbiter: directed scenarios plus randomized traffic.
// A byte-level reference memory and a denial counter predict grants, SRAM
// strobes and read data; expected reads go into a queue that an independent
// monitor drains whenever the DUT raises an rvalid.
module tb_dtcm_port_arbiter;

    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic            clk = 1'b0;
    logic            cpurst;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic [DW-1:0]   m0_wdat, m1_wdat;
    logic [3:0]      m0_be, m1_be;
    logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0]   m0_rdat, m1_rdat;
    logic            sram_cs, sram_we;
    logic [AW-3:0]   sram_addr;
    logic [DW-1:0]   sram_wdat;
    logic [3:0]      sram_be;
    logic [DW-1:0]   sram_rdat;

    dtcm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .cpurst(cpurst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdat(m0_wdat), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdat(m0_rdat),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdat(m1_wdat), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdat(m1_rdat),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdat(sram_wdat),
        .sram_be(sram_be), .sram_rdat(sram_rdat)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [31:0] cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Power-up contents of any word never written
    function automatic logic [31:0] init_word(input logic [21:0] w);
        return ({10'b0, w} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // ---------------- SRAM macro model (environment) ----------------
    logic [31:0] smem [int];
    always @(posedge clk) begin
        if (sram_cs) begin
            logic [31:0] w;
            w = smem.exists(int'(sram_addr)) ? smem[int'(sram_addr)] : init_word(sram_addr);
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) w[8*b +: 8] = sram_wdat[8*b +: 8];
                smem[int'(sram_addr)] = w;
            end else begin
                sram_rdat <= w;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] bmem [int];   // byte-addressed view of the DTCM
    int waited = 0;           // consecutive cycles m1 asked and was refused

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        logic [31:0] iw;
        if (bmem.exists(int'(a))) return bmem[int'(a)];
        iw = init_word(a[23:2]);
        return iw[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input logic [23:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = ref_byte({a[23:2], 2'(i)});
        return w;
    endfunction

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic [31:0] cyc;
    } rd_exp_t;
    rd_exp_t sb[$];

    // One clock of stimulus; predicts and checks the combinational side
    task automatic step(
        input bit rst_i,
        input bit r0, input bit w0, input logic [23:0] a0, input logic [31:0] d0, input logic [3:0] b0,
        input bit r1, input bit w1, input logic [23:0] a1, input logic [31:0] d1, input logic [3:0] b1,
        output bit g0, output bit g1);
        bit          win1, win0, we;
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        @(posedge clk); #1;
        cpurst = rst_i;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdat = d0; m0_be = b0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdat = d1; m1_be = b1;
        @(negedge clk);
        // loader wins when core is idle or after LIM straight refusals
        win1 = r1 && (!r0 || (!rst_i && waited >= LIM));
        win0 = r0 && !win1;
        chk("m0_gnt", m0_gnt, win0);
        chk("m1_gnt", m1_gnt, win1);
        chk("sram_cs", sram_cs, win0 | win1);
        we = win1 ? w1 : w0;
        a  = win1 ? a1 : a0;
        d  = win1 ? d1 : d0;
        b  = win1 ? b1 : b0;
        if (win0 || win1) begin
            chk("sram_we", sram_we, we);
            chk("sram_addr", sram_addr, a[23:2]);
            chk("sram_be", sram_be, we ? b : 4'hF);
            if (we) chk("sram_wdat", sram_wdat, d);
        end else begin
            chk("idle_sram", {sram_we, sram_addr, sram_be}, '0);
        end
        if (rst_i) begin
            sb.delete();
            chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
            chk("rst_rdat", {m0_rdat, m1_rdat}, 64'h0);
        end
        if ((win0 || win1) && we) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) bmem[int'({a[23:2], 2'(i)})] = d[8*i +: 8];
        end else if ((win0 || win1) && !rst_i) begin
            sb.push_back('{owner: win1, data: ref_word(a), cyc: cyc});
        end
        if (rst_i || !r1 || win1) waited = 0;
        else waited++;
        g0 = win0;
        g1 = win1;
    endtask

    // ---------------- read-return monitor ----------------
    always @(negedge clk) begin
        rd_exp_t e;
        if (!cpurst) begin
            if (m0_rvalid || m1_rvalid) begin
                chk("rvalid_exclusive", m0_rvalid & m1_rvalid, 1'b0);
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_owner", m1_rvalid, e.owner);
                    chk("rd_data", m1_rvalid ? m1_rdat : m0_rdat, e.data);
                    chk("rd_other_zero", m1_rvalid ? m0_rdat : m1_rdat, 32'h0);
                    chk("rd_latency", e.cyc + 1, cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("rd_missing", 1'b0, 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total %0d", total);
        $fatal(1);
    end

    initial begin
        bit g0, g1;
        bit p0, p1, w0, w1;
        logic [23:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  b0, b1;
        cpurst = 1'b1;
        {m0_req, m0_we, m1_req, m1_we} = '0;
        {m0_addr, m1_addr, m0_wdat, m1_wdat, m0_be, m1_be} = '0;

        // reset with both requesting, then a plain core read of 0x10
        step(1, 1, 0, 24'h10, 0, 0, 1, 0, 24'h40, 0, 0, g0, g1);
        step(1, 1, 0, 24'h10, 0, 0, 1, 0, 24'h40, 0, 0, g0, g1);
        step(0, 1, 0, 24'h10, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // both hammering: m0,m0,m0,m0,m1 repeating, reads at moving addresses
        for (int i = 0; i < 15; i++)
            step(0, 1, 0, 24'(32'h100 + 4*i), 0, 0, 1, 0, 24'(32'h200 + 4*i), 0, 0, g0, g1);

        // loader partial write then read-back of the same word
        step(0, 0, 0, 0, 0, 0, 1, 1, 24'h20, 32'hDEADBEEF, 4'b0011, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 24'h20, 0, 0, g0, g1);

        // alternating single-cycle owners back to back
        step(0, 1, 0, 24'h100, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 24'h104, 0, 0, g0, g1);
        step(0, 1, 0, 24'h108, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // m1 refused 3 times, drops, then needs 4 fresh refusals
        for (int i = 0; i < 3; i++) step(0, 1, 1, 24'h300, 32'h1, 4'hF, 1, 0, 24'h304, 0, 0, g0, g1);
        step(0, 1, 1, 24'h300, 32'h2, 4'hF, 0, 0, 0, 0, 0, g0, g1);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 24'h300, 32'h3, 4'hF, 1, 0, 24'h304, 0, 0, g0, g1);

        // reset one cycle after a granted read: return dropped, next read fine
        step(0, 1, 0, 24'h44, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 24'h44, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // randomized traffic, requests held until granted (or occasionally dropped)
        p0 = 0; p1 = 0;
        {w0, w1, a0, a1, d0, d1, b0, b1} = '0;
        for (int i = 0; i < 600; i++) begin
            if (!p0 && $urandom_range(0, 99) < 70) begin
                p0 = 1; w0 = $urandom_range(0, 1);
                a0 = 24'({$urandom_range(0, 3), 20'h0} | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                d0 = $urandom; b0 = 4'($urandom);
            end else if (p0 && $urandom_range(0, 99) < 4) p0 = 0;
            if (!p1 && $urandom_range(0, 99) < 70) begin
                p1 = 1; w1 = $urandom_range(0, 1);
                a1 = 24'({$urandom_range(0, 3), 20'h0} | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                d1 = $urandom; b1 = 4'($urandom);
            end else if (p1 && $urandom_range(0, 99) < 4) p1 = 0;
            step($urandom_range(0, 199) == 0, p0, w0, a0, d0, b0, p1, w1, a1, d1, b1, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
